// File: rtl/ula_pkg.sv
// Shared opcode/funct3 encodings and FSM state type for the ula_mc ALU.
package ula_pkg;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_B = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

endpackage

// File: rtl/ula_mdu_iter.sv
// Iterative shift-add multiplier / restoring divider over operand magnitudes,
// with sign fix-up applied to the final step's value.
module ula_mdu_iter
  import ula_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            last,
  output logic [XLEN-1:0] res
);

  localparam int CW = $clog2(XLEN);

  logic            busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d, prod_fix;
  logic [XLEN-1:0] opb_q, opb_d;
  logic            is_div_q, is_div_d;
  logic            neg_lo_q, neg_lo_d;
  logic            neg_hi_q, neg_hi_d;
  logic            sel_hi_q, sel_hi_d;

  logic            a_sgn, b_sgn;
  logic [XLEN-1:0] a_mag, b_mag, diff, quo_fix, rem_fix;
  logic [XLEN:0]   sum, shifted;
  logic            ge;

  always_comb begin
    if (funct3[2]) begin
      a_sgn = ~funct3[0] & a[XLEN-1];
      b_sgn = ~funct3[0] & b[XLEN-1];
    end else begin
      a_sgn = (funct3 != F3_MULHU) & a[XLEN-1];
      b_sgn = ((funct3 == F3_MUL) | (funct3 == F3_MULH)) & b[XLEN-1];
    end
    a_mag = a_sgn ? -a : a;
    b_mag = b_sgn ? -b : b;
  end

  assign last = busy_q & (cnt_q == CW'(XLEN - 1));

  // Multiply and divide share acc_q: {high/remainder, low/quotient}.
  always_comb begin
    sum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    shifted = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    ge      = shifted >= {1'b0, opb_q};
    diff    = shifted[XLEN-1:0] - opb_q;

    busy_d   = busy_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    sel_hi_d = sel_hi_q;

    if (start) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      is_div_d = funct3[2];
      neg_lo_d = a_sgn ^ b_sgn;
      neg_hi_d = a_sgn;
      sel_hi_d = funct3[2] ? funct3[1] : (funct3[1:0] != 2'b00);
      acc_d    = {{XLEN{1'b0}}, (funct3[2] ? a_mag : b_mag)};
      opb_d    = funct3[2] ? b_mag : a_mag;
    end else if (busy_q) begin
      cnt_d = cnt_q + 1'b1;
      if (is_div_q)
        acc_d = {(ge ? diff : shifted[XLEN-1:0]), acc_q[XLEN-2:0], ge};
      else
        acc_d = {sum, acc_q[XLEN-1:1]};
      if (last)
        busy_d = 1'b0;
    end
  end

  always_comb begin
    prod_fix = neg_lo_q ? -acc_d : acc_d;
    quo_fix  = neg_lo_q ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
    rem_fix  = neg_hi_q ? -acc_d[2*XLEN-1:XLEN] : acc_d[2*XLEN-1:XLEN];
    if (is_div_q)
      res = sel_hi_q ? rem_fix : quo_fix;
    else
      res = sel_hi_q ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      sel_hi_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      sel_hi_q <= sel_hi_d;
    end
  end

endmodule

// File: rtl/ula_mc.sv
// Multi-cycle RV32/64 integer ALU: single-cycle base ops and branches,
// iterative M-extension multiply/divide through ula_mdu_iter.
module ula_mc
  import ula_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic [6:0]      op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            take_b
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            take_b_q, take_b_d;
  logic            out_valid_q, out_valid_d;

  logic            is_r, is_i, is_b, is_mul, is_div;
  logic            div_zero, div_ovf, mdu_start, mdu_last, br_take;
  logic [SHW-1:0]  shamt;
  logic signed [XLEN-1:0] sra_res;
  logic [XLEN-1:0] alu_res, byp_res, mdu_res;

  assign is_r     = (op == OP_R);
  assign is_i     = (op == OP_I);
  assign is_b     = (op == OP_B);
  assign is_mul   = is_r & funct7[0] & ~funct3[2];
  assign is_div   = is_r & funct7[0] & funct3[2];
  assign div_zero = (in_b == '0);
  assign div_ovf  = ~funct3[0] & (in_a == MIN_NEG) & (&in_b);
  assign in_ready = (state_q == IDLE);
  assign mdu_start = in_valid & in_ready & (is_mul | (is_div & ~div_zero & ~div_ovf));
  assign shamt    = in_b[SHW-1:0];
  assign sra_res  = $signed(in_a) >>> shamt;

  // Unknown opcodes and branches fall through to ADD.
  always_comb begin
    alu_res = in_a + in_b;
    if (is_r | is_i) begin
      case (funct3)
        F3_ADD:  alu_res = (is_r & funct7[5]) ? in_a - in_b : in_a + in_b;
        F3_SLL:  alu_res = in_a << shamt;
        F3_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(in_a) < $signed(in_b)};
        F3_SLTU: alu_res = {{(XLEN-1){1'b0}}, in_a < in_b};
        F3_XOR:  alu_res = in_a ^ in_b;
        F3_SR:   alu_res = funct7[5] ? sra_res : in_a >> shamt;
        F3_OR:   alu_res = in_a | in_b;
        F3_AND:  alu_res = in_a & in_b;
        default: alu_res = in_a + in_b;
      endcase
    end
  end

  always_comb begin
    case (funct3)
      F3_BEQ:  br_take = (in_a == in_b);
      F3_BNE:  br_take = (in_a != in_b);
      F3_BLT:  br_take = $signed(in_a) < $signed(in_b);
      F3_BGE:  br_take = $signed(in_a) >= $signed(in_b);
      F3_BLTU: br_take = in_a < in_b;
      F3_BGEU: br_take = in_a >= in_b;
      default: br_take = 1'b0;
    endcase
    if (div_zero)
      byp_res = funct3[1] ? in_a : '1;
    else
      byp_res = funct3[1] ? '0 : in_a;
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    take_b_d    = take_b_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (is_mul) begin
            state_d = MUL;
          end else if (mdu_start) begin
            state_d = DIV;
          end else begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            take_b_d    = is_b & br_take;
            result_d    = is_div ? byp_res : alu_res;
          end
        end
      end
      MUL, DIV: begin
        if (mdu_last) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          take_b_d    = 1'b0;
          result_d    = mdu_res;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      result_q    <= '0;
      take_b_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      take_b_q    <= take_b_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign take_b    = take_b_q;
  assign out_valid = out_valid_q;

  ula_mdu_iter #(.XLEN(XLEN)) u_mdu (
    .clk    (clk),
    .reset  (reset),
    .start  (mdu_start),
    .funct3 (funct3),
    .a      (in_a),
    .b      (in_b),
    .last   (mdu_last),
    .res    (mdu_res)
  );

endmodule

// File: doc/ula_mc.md
ULA_MC -- requirements
Module: ula_mc

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath width; power of two, 16..64.
REQ-002 SHALL have parameter SHW, default $clog2(XLEN): shift-amount width, derived and not overridden.
REQ-003 SHALL have port clk  input  1: sole clock, rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1: operation request.
REQ-006 SHALL have port in_ready  output  1: block accepts a request this cycle.
REQ-007 SHALL have port in_a  input  XLEN: rs1 operand.
REQ-008 SHALL have port in_b  input  XLEN: rs2 or immediate operand.
REQ-009 SHALL have port funct7  input  7: bit5 selects SUB/SRA; bit0 selects M-extension when op is R-type.
REQ-010 SHALL have port funct3  input  3: operation or branch condition.
REQ-011 SHALL have port op  input  7: opcode (0110011 R-type, 0010011 I-type, 1100011 branch).
REQ-012 SHALL have port out_valid  output  1: result and take_b are valid.
REQ-013 SHALL have port out_ready  input  1: consumer accepts the result.
REQ-014 SHALL have port result  output  XLEN: registered result.
REQ-015 SHALL have port take_b  output  1: registered branch decision; 0 for non-branch ops.

Function
REQ-016 SHALL implement the FSM states IDLE, MUL, DIV and DONE.
REQ-017 SHALL assert in_ready only in IDLE; a request is accepted when in_valid & in_ready.
REQ-018 SHALL, on an accepted base op (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND or a branch), go IDLE->DONE with a latency of 1 cycle.
REQ-019 SHALL apply SUB only for R-type with funct7[5]=1; for I-type, funct7[5] SHALL select SRA only when funct3=101.
REQ-020 SHALL take shift amounts from in_b[SHW-1:0]; SRA SHALL sign-fill from in_a[XLEN-1].
REQ-021 SHALL compute take_b as BEQ/BNE/BLT/BGE/BLTU/BGEU per funct3; funct3 010/011 on a branch SHALL give take_b=0.
REQ-022 SHALL, on MUL/MULH/MULHSU/MULHU (R-type, funct7[0]=1, funct3[2]=0), go IDLE->MUL, run an XLEN-cycle shift-add over a 2*XLEN product, then go to DONE (latency XLEN+1).
REQ-023 SHALL, on DIV/DIVU/REM/REMU (funct3[2]=1), go IDLE->DIV, run an XLEN-cycle restoring divide over magnitudes, apply sign fix-up, then go to DONE (latency XLEN+1).
REQ-024 SHALL, on divisor 0, bypass DIV and reach DONE in 1 cycle with quotient all-ones and remainder = in_a.
REQ-025 SHALL, on signed overflow (in_a = most-negative, in_b = -1), bypass DIV and reach DONE in 1 cycle with quotient = in_a and remainder = 0.
REQ-026 SHALL, in DONE, hold out_valid=1 with result and take_b stable until out_ready=1, then go to IDLE on the next edge.
REQ-027 SHALL NOT accept a new request in the same cycle as a DONE->IDLE transition.
REQ-028 SHALL treat an unrecognised opcode as ADD.

Reset
REQ-029 SHALL, on reset asserted, immediately force state=IDLE, out_valid=0, result=0, take_b=0 and clear the iteration counter and accumulators.
REQ-030 SHALL have reset abort an in-flight MUL/DIV with no result produced; in_ready SHALL be 1 on the first edge after deassertion.

Structure
REQ-031 SHALL place the opcode constants, funct3 encodings and the state enum in the shared package ula_pkg.
REQ-032 SHALL place the iterative multiply/divide datapath (counter, accumulators, sign fix-up) in the sub-module ula_mdu_iter.
REQ-033 SHALL keep the base-op and branch logic combinational and register it once at IDLE->DONE.

Verification
REQ-034 SHALL cover: ADD 0x7FFFFFFF+1 with XLEN=32 -> result 0x80000000, out_valid one cycle after acceptance.
REQ-035 SHALL cover: SRA 0x80000000 by 31 -> 0xFFFFFFFF; SLL by in_b=0x21 -> shift of 1.
REQ-036 SHALL cover: BLT -1 vs 1 -> take_b=1; BLTU same operands -> take_b=0.
REQ-037 SHALL cover: MULH 0x80000000 * 0x80000000 -> 0x40000000 after 33 cycles; in_ready=0 throughout.
REQ-038 SHALL cover: DIV 7/0 -> 0xFFFFFFFF; REM 0x80000000 % -1 -> 0, each in 1 cycle.
REQ-039 SHALL cover: reset pulsed during DIV cycle 10 -> no out_valid, next ADD completes normally; out_ready held 0 for 5 cycles -> result stable.
